// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main control unit and the ALU control
// decoder: opcodes, ALUop codes, datapath mux selects, the FSM state
// enumeration and the bundle of datapath control signals.
package ctrl_pkg;

    // Opcodes (IR[31:26]) handled by the control unit
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUop codes consumed by the ALU control decoder; 2'b11 is never driven
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // FSM states; encodings 12..15 are unused and recover to S_FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Every datapath control driven by the main control unit
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational state-to-control decoder for the main control FSM.
// Outputs depend on the state plus mem_ready (FETCH/MEMWR), zero (BRANCH)
// and the opcode (DECODE, for the illegal-opcode pulse).
module main_ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output ctrl_t      ctrl_o
);

    // Per-state control decode; anything not set in a state stays 0
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target is computed speculatively here
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
                case (opcode_i)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ctrl_o.illegal = 1'b0;
                    default:                                        ctrl_o.illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord       = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_RT;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.pc_src     = PCSRC_ALUOUT;
                ctrl_o.pc_write   = zero_i;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src     = PCSRC_JUMP;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS-subset main control unit. Holds the state register and
// next-state logic; output decode lives in main_ctrl_outdec. While rst is
// high the decoder sees FETCH (so mux selects show FETCH values) and every
// strobe is forced low, so an aborted store never writes in the reset cycle.
module main_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    state_t dec_state;
    ctrl_t  ctrl;

    // Next-state logic: wait states hold until mem_ready, others advance
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR and the IR holds the opcode stable
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign dec_state = rst ? S_FETCH : state_q;

    main_ctrl_outdec u_outdec (
        .state_i     (dec_state),
        .opcode_i    (opcode),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ctrl_o      (ctrl)
    );

    // Strobes are gated by reset; mux selects pass through from the decoder
    always_comb begin
        IorD       = ctrl.iord;
        MemRead    = ctrl.mem_read   & ~rst;
        MemWrite   = ctrl.mem_write  & ~rst;
        IRWrite    = ctrl.ir_write   & ~rst;
        RegDst     = ctrl.reg_dst;
        MemtoReg   = ctrl.mem_to_reg;
        RegWrite   = ctrl.reg_write  & ~rst;
        ALUSrcA    = ctrl.alu_src_a;
        ALUSrcB    = ctrl.alu_src_b;
        ALUop      = ctrl.alu_op;
        PCSrc      = ctrl.pc_src;
        PCWrite    = ctrl.pc_write   & ~rst;
        instr_done = ctrl.instr_done & ~rst;
        illegal    = ctrl.illegal    & ~rst;
        state_o    = rst ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Bench for main_ctrl_fsm. A reference model expands each instruction into
// its sequence of phases and gives the expected control word per phase.
module tb_main_ctrl_fsm;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;

    typedef enum {
        PH_RESET, PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB, PH_MEMWR,
        PH_EXEC, PH_ALUWB, PH_BRANCH, PH_ADDIEX, PH_ADDIWB, PH_JUMP
    } ph_t;

    // Clock / reset / inputs
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUop, PCSrc;
    logic       PCWrite, instr_done, illegal;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    main_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUop      (ALUop),
        .PCSrc      (PCSrc),
        .PCWrite    (PCWrite),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    // Scoreboard
    int          total_cnt = 0;
    int          bad_cnt = 0;
    logic [20:0] exp_q[$];
    logic [20:0] got_w;

    assign got_w = {state_o, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                    RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSrc, PCWrite, instr_done, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return (op == T_RTYPE) || (op == T_LW) || (op == T_SW) ||
               (op == T_BEQ) || (op == T_J) || (op == T_ADDI);
    endfunction

    // Reference control word for one cycle of a phase
    function automatic logic [20:0] exp_ctl(input ph_t ph, input logic rdy, input logic z,
                                            input logic legal);
        logic [3:0] st;
        logic iord, mr, mw, irw, rd, m2r, rw, srca, pcw, done, ill;
        logic [1:0] srcb, aop, pcs;
        {st, iord, mr, mw, irw, rd, m2r, rw, srca, srcb, aop, pcs, pcw, done, ill} = '0;
        case (ph)
            PH_RESET:  srcb = 2'b01;
            PH_FETCH:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            PH_DECODE: begin st = 1; srcb = 2'b11; ill = !legal; end
            PH_MEMADR: begin st = 2; srca = 1; srcb = 2'b10; end
            PH_MEMRD:  begin st = 3; iord = 1; mr = 1; end
            PH_MEMWB:  begin st = 4; m2r = 1; rw = 1; done = 1; end
            PH_MEMWR:  begin st = 5; iord = 1; mw = 1; done = rdy; end
            PH_EXEC:   begin st = 6; srca = 1; aop = 2'b10; end
            PH_ALUWB:  begin st = 7; rd = 1; rw = 1; done = 1; end
            PH_BRANCH: begin st = 8; srca = 1; aop = 2'b01; pcs = 2'b01; pcw = z; done = 1; end
            PH_ADDIEX: begin st = 9; srca = 1; srcb = 2'b10; end
            PH_ADDIWB: begin st = 10; rw = 1; done = 1; end
            PH_JUMP:   begin st = 11; pcs = 2'b10; pcw = 1; done = 1; end
            default:   st = 4'hf;
        endcase
        return {st, iord, mr, mw, irw, rd, m2r, rw, srca, srcb, aop, pcs, pcw, done, ill};
    endfunction

    // Driver: one cycle in a given phase, then compare the control word
    task automatic step(input ph_t ph, input logic [5:0] op, input logic rdy, input logic z);
        logic [20:0] e;
        @(negedge clk);
        rst = (ph == PH_RESET);
        opcode = op;
        mem_ready = rdy;
        zero = z;
        exp_q.push_back(exp_ctl(ph, rdy, z, is_legal(op)));
        #1;
        e = exp_q.pop_front();
        check_eq(ph.name(), 32'(got_w), 32'(e));
    endtask

    // Model of one instruction: fetch (with wf wait cycles), then its phases
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input logic z);
        ph_t seq[$];
        seq.push_back(PH_DECODE);
        if (op == T_LW) begin
            seq.push_back(PH_MEMADR); seq.push_back(PH_MEMRD); seq.push_back(PH_MEMWB);
        end else if (op == T_SW) begin
            seq.push_back(PH_MEMADR); seq.push_back(PH_MEMWR);
        end else if (op == T_RTYPE) begin
            seq.push_back(PH_EXEC); seq.push_back(PH_ALUWB);
        end else if (op == T_BEQ) begin
            seq.push_back(PH_BRANCH);
        end else if (op == T_J) begin
            seq.push_back(PH_JUMP);
        end else if (op == T_ADDI) begin
            seq.push_back(PH_ADDIEX); seq.push_back(PH_ADDIWB);
        end
        for (int i = 0; i < wf; i++) step(PH_FETCH, 6'($urandom), 1'b0, 1'($urandom));
        step(PH_FETCH, 6'($urandom), 1'b1, 1'($urandom));
        foreach (seq[k]) begin
            if (seq[k] == PH_MEMRD || seq[k] == PH_MEMWR) begin
                for (int i = 0; i < wm; i++) step(seq[k], op, 1'b0, 1'($urandom));
                step(seq[k], op, 1'b1, 1'($urandom));
            end else begin
                step(seq[k], op, 1'($urandom), (seq[k] == PH_BRANCH) ? z : 1'($urandom));
            end
        end
    endtask

    // Cycles from FETCH entry back to FETCH with mem_ready held high (bounded)
    task automatic measure_lat(input logic [5:0] op, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            rst = 1'b0;
            opcode = op;
            mem_ready = 1'b1;
            zero = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end while (state_o != 4'd0 && n < 20);
        check_eq("lat", 32'(n), 32'(exp_n));
    endtask

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        do op = 6'($urandom); while (is_legal(op));
        return op;
    endfunction

    initial begin
        logic [5:0] op;
        int kind;

        // Reset held 3 cycles with mem_ready high: strobes must stay low
        for (int i = 0; i < 3; i++) step(PH_RESET, 6'd0, 1'b1, 1'b0);

        // R-type: states 0,1,6,7,0
        run_instr(T_RTYPE, 0, 0, 1'b0);
        // lw with 2 wait cycles in MEMRD
        run_instr(T_LW, 0, 2, 1'b0);
        // beq taken, then not taken
        run_instr(T_BEQ, 0, 0, 1'b1);
        run_instr(T_BEQ, 0, 0, 1'b0);
        // unsupported opcode
        run_instr(6'b111111, 0, 0, 1'b0);
        // j then addi
        run_instr(T_J, 0, 0, 1'b0);
        run_instr(T_ADDI, 0, 0, 1'b0);

        // sw aborted by reset during the MEMWR wait
        step(PH_FETCH, 6'($urandom), 1'b1, 1'b0);
        step(PH_DECODE, T_SW, 1'b1, 1'b0);
        step(PH_MEMADR, T_SW, 1'b0, 1'b0);
        step(PH_MEMWR, T_SW, 1'b0, 1'b0);
        step(PH_RESET, T_SW, 1'b1, 1'b0);
        step(PH_FETCH, T_SW, 1'b0, 1'b0);

        // Instruction latencies with mem_ready held high
        measure_lat(T_LW, 5);
        measure_lat(T_SW, 4);
        measure_lat(T_RTYPE, 4);
        measure_lat(T_ADDI, 4);
        measure_lat(T_BEQ, 3);
        measure_lat(T_J, 3);
        measure_lat(rand_illegal(), 2);

        // Randomized instruction stream with random memory wait states
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: op = T_RTYPE;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_BEQ;
                4: op = T_J;
                5: op = T_ADDI;
                default: op = rand_illegal();
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
